// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised oversampling UART receiver with 3-sample majority vote,
// parity/frame checking and a valid/ready output. Optional break detection: UART_RX_BREAK_DETECT_EN.
module uart_rx_param #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                 clk16,
    input  logic                 rst,
    input  logic                 serial_data_in,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] para_data_out,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
`ifdef UART_RX_BREAK_DETECT_EN
    output logic                 break_det,
`endif
    output logic                 busy
);

    localparam int unsigned CNT_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned BITS_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_V0   = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_V1   = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    logic                 r_sync1;
    logic                 r_sync2;
    state_t               r_state;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [BITS_W-1:0]    r_data_cnt;
    logic                 r_stop_idx;
    logic                 r_v0;
    logic                 r_v1;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_acc;
    logic                 r_par_err;
    logic                 r_frm_err;
    logic                 r_done;

    logic                 w_rxd;
    logic                 w_maj;
    logic                 w_decide;
    logic                 w_boundary;
    logic                 w_final_dec;
    logic                 w_hold;

    // Two-flop synchroniser; idles high so reset does not look like a start edge.
    always_ff @(posedge clk16 or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= serial_data_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxd       = r_sync2;
    assign w_maj       = (r_v0 & r_v1) | (r_v0 & w_rxd) | (r_v1 & w_rxd);
    assign w_decide    = (r_bit_cnt == CNT_DEC);
    assign w_boundary  = (r_bit_cnt == CNT_LAST);
    assign w_final_dec = (r_state == ST_STOP) && w_decide && (r_stop_idx == 1'(STOP_BITS - 1));

    // Frame FSM: the third vote sample is taken live at the decision count.
    always_ff @(posedge clk16 or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_data_cnt <= '0;
            r_stop_idx <= 1'b0;
            r_v0       <= 1'b1;
            r_v1       <= 1'b1;
            r_shift    <= '0;
            r_par_acc  <= 1'b0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_done     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != ST_IDLE) begin
                r_bit_cnt <= w_boundary ? '0 : r_bit_cnt + CNT_W'(1);
                if (r_bit_cnt == CNT_V0) r_v0 <= w_rxd;
                if (r_bit_cnt == CNT_V1) r_v1 <= w_rxd;
            end
            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt <= '0;
                    if (!w_rxd && !w_hold) begin
                        r_state    <= ST_START;
                        busy       <= 1'b1;
                        r_frm_err  <= 1'b0;
                        r_par_err  <= 1'b0;
                        r_par_acc  <= 1'b0;
                        r_data_cnt <= '0;
                        r_stop_idx <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_decide && w_maj) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (w_boundary) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_decide) begin
                        r_shift    <= {w_maj, r_shift[DATA_BITS-1:1]};
                        r_par_acc  <= r_par_acc ^ w_maj;
                        r_data_cnt <= r_data_cnt + BITS_W'(1);
                    end
                    if (w_boundary && (r_data_cnt == BITS_W'(DATA_BITS))) begin
                        r_state <= (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (w_decide) begin
                        r_par_err <= (PARITY_MODE == 2) ? ~(r_par_acc ^ w_maj) : (r_par_acc ^ w_maj);
                    end
                    if (w_boundary) r_state <= ST_STOP;
                end
                ST_STOP: begin
                    if (w_decide) begin
                        if (!w_maj) r_frm_err <= 1'b1;
                        // Leave at the final decision so an early next start edge is caught.
                        if (w_final_dec) begin
                            r_state <= ST_IDLE;
                            busy    <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Output holding register with valid/ready handshake and sticky overrun.
    always_ff @(posedge clk16 or posedge rst) begin
        if (rst) begin
            para_data_out <= '0;
            rx_valid      <= 1'b0;
            frame_err     <= 1'b0;
            parity_err    <= 1'b0;
            overrun       <= 1'b0;
        end else if (r_done) begin
            para_data_out <= r_shift;
            frame_err     <= r_frm_err;
            parity_err    <= r_par_err;
            rx_valid      <= 1'b1;
            if (rx_valid && !rx_ready) overrun <= 1'b1;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    logic             r_par_bit;
    logic             r_brk;
    logic             r_brk_wait;
    logic [CNT_W-1:0] r_idle_cnt;
    logic             w_brk_now;

    assign w_brk_now = (r_shift == '0) && !r_par_bit && (r_frm_err || !w_maj);
    assign w_hold    = r_brk_wait;

    // Break classification and the idle-high qualification before the next start.
    always_ff @(posedge clk16 or posedge rst) begin
        if (rst) begin
            r_par_bit  <= 1'b0;
            r_brk      <= 1'b0;
            r_brk_wait <= 1'b0;
            r_idle_cnt <= '0;
            break_det  <= 1'b0;
        end else begin
            if ((r_state == ST_PARITY) && w_decide) r_par_bit <= w_maj;
            if (w_final_dec) begin
                r_brk <= w_brk_now;
                if (w_brk_now) begin
                    r_brk_wait <= 1'b1;
                    r_idle_cnt <= '0;
                end
            end else if (r_brk_wait) begin
                if (!w_rxd) begin
                    r_idle_cnt <= '0;
                end else if (r_idle_cnt == CNT_LAST) begin
                    r_brk_wait <= 1'b0;
                end else begin
                    r_idle_cnt <= r_idle_cnt + CNT_W'(1);
                end
            end
            if (r_done) begin
                break_det <= r_brk;
            end else if (rx_valid && rx_ready) begin
                break_det <= 1'b0;
            end
        end
    end
`else
    assign w_hold = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: randomized self-checking bench for uart_rx_param (8N1 instance plus
// a 7-bit even-parity instance), checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int OS = 16;

    logic       clk16 = 1'b0;
    logic       rst   = 1'b1;
    logic       sdi   = 1'b1;
    logic       rdy   = 1'b1;
    logic [7:0] dout;
    logic       vld, fe, pe, ovr, bsy;

    logic       sdi_p = 1'b1;
    logic       rdy_p = 1'b1;
    logic [6:0] dout_p;
    logic       vld_p, fe_p, pe_p, ovr_p, bsy_p;
`ifdef UART_RX_BREAK_DETECT_EN
    logic       brk, brk_p;
`endif

    int cyc      = 0;
    int pass_cnt = 0;
    int total    = 0;
    int vld_hi   = 0;

    int         m_cyc[$];
    logic [8:0] m_d[$];
    bit         m_fe[$];
    bit         m_pe[$];
    bit         m_brk[$];
    int         p_cyc[$];
    logic [8:0] p_d[$];
    bit         p_fe[$];
    bit         p_pe[$];
    logic       vld_q  = 1'b0;
    logic       vld_pq = 1'b0;

    uart_rx_param u_dut (
        .clk16          (clk16),
        .rst            (rst),
        .serial_data_in (sdi),
        .rx_ready       (rdy),
        .para_data_out  (dout),
        .rx_valid       (vld),
        .frame_err      (fe),
        .parity_err     (pe),
        .overrun        (ovr),
`ifdef UART_RX_BREAK_DETECT_EN
        .break_det      (brk),
`endif
        .busy           (bsy)
    );

    uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(OS), .PARITY_MODE(1), .STOP_BITS(1)) u_par (
        .clk16          (clk16),
        .rst            (rst),
        .serial_data_in (sdi_p),
        .rx_ready       (rdy_p),
        .para_data_out  (dout_p),
        .rx_valid       (vld_p),
        .frame_err      (fe_p),
        .parity_err     (pe_p),
        .overrun        (ovr_p),
`ifdef UART_RX_BREAK_DETECT_EN
        .break_det      (brk_p),
`endif
        .busy           (bsy_p)
    );

    always #5 clk16 = ~clk16;
    always @(posedge clk16) cyc <= cyc + 1;

    // Record every rising edge of rx_valid with the word and flags presented with it.
    always @(posedge clk16) begin
        #1;
        if (vld) vld_hi++;
        if (vld && !vld_q) begin
            m_cyc.push_back(cyc);
            m_d.push_back(9'(dout));
            m_fe.push_back(fe);
            m_pe.push_back(pe);
`ifdef UART_RX_BREAK_DETECT_EN
            m_brk.push_back(brk);
`else
            m_brk.push_back(1'b0);
`endif
        end
        vld_q = vld;
        if (vld_p && !vld_pq) begin
            p_cyc.push_back(cyc);
            p_d.push_back(9'(dout_p));
            p_fe.push_back(fe_p);
            p_pe.push_back(pe_p);
        end
        vld_pq = vld_p;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d so far", pass_cnt, total);
        $fatal(1, "watchdog");
    end

    // Line-level frame: start 0, data LSB first, optional parity, stop bits.
    function automatic logic [15:0] mk_frame(input logic [8:0] d, input int dbits, input int par,
                                             input logic pbit, input logic [1:0] stops);
        logic [15:0] f;
        int idx;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < dbits; i++) f[1+i] = d[i];
        idx = 1 + dbits;
        if (par != 0) begin
            f[idx] = pbit;
            idx++;
        end
        f[idx]   = stops[0];
        f[idx+1] = stops[1];
        return f;
    endfunction

    function automatic int exp_lat(input int nbits);
        return 3 + OS * (nbits - 1) + OS / 2 + 2;
    endfunction

    task automatic send_line(input logic [15:0] bits, input int n, input bit to_par);
        for (int i = 0; i < n; i++) begin
            if (to_par) sdi_p = bits[i];
            else sdi = bits[i];
            repeat (OS) begin
                @(posedge clk16);
                #1;
            end
        end
        if (to_par) sdi_p = 1'b1;
        else sdi = 1'b1;
    endtask

    task automatic wait_mon(input bit par, input int want, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ((par ? p_cyc.size() : m_cyc.size()) >= want) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk16);
            #2;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk16);
        #1;
        total++; if (vld !== 1'b0) $display("FAIL reset_valid: got %b expected 0", vld); else pass_cnt++;
        total++; if (dout !== 8'h00) $display("FAIL reset_data: got %h expected 00", dout); else pass_cnt++;
        total++; if ({fe, pe} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {fe, pe}); else pass_cnt++;
        total++; if (ovr !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", ovr); else pass_cnt++;
        total++; if (bsy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bsy); else pass_cnt++;
        rst = 1'b0;
        repeat (4) @(posedge clk16);
        #1;
        total++; if (bsy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", bsy); else pass_cnt++;
        total++; if (vld_p !== 1'b0) $display("FAIL reset_par_valid: got %b expected 0", vld_p); else pass_cnt++;
    endtask

    task automatic test_basic();
        int base, t0, hi0;
        bit ok;
        base = m_cyc.size();
        hi0  = vld_hi;
        @(posedge clk16);
        #1;
        t0 = cyc + 1;
        send_line(mk_frame(9'h0A5, 8, 0, 1'b0, 2'b11), 10, 1'b0);
        wait_mon(1'b0, base + 1, ok);
        total++; if (!ok) $display("FAIL basic_timeout: got no rx_valid, expected one"); else pass_cnt++;
        if (ok) begin
            total++; if (m_cyc[base] - t0 !== exp_lat(10)) $display("FAIL basic_latency: got %0d expected %0d", m_cyc[base] - t0, exp_lat(10)); else pass_cnt++;
            total++; if (m_d[base] !== 9'h0A5) $display("FAIL basic_data: got %h expected 0a5", m_d[base]); else pass_cnt++;
            total++; if ({m_fe[base], m_pe[base]} !== 2'b00) $display("FAIL basic_flags: got %b expected 00", {m_fe[base], m_pe[base]}); else pass_cnt++;
        end
        repeat (OS) @(posedge clk16);
        #1;
        total++; if (vld_hi - hi0 !== 1) $display("FAIL basic_pulse: got %0d valid cycles expected 1", vld_hi - hi0); else pass_cnt++;
    endtask

    task automatic test_random_frames();
        int base, t0;
        bit ok;
        logic [8:0] d;
        logic st;
        for (int k = 0; k < 6; k++) begin
            d  = 9'($urandom_range(1, 255));
            st = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            base = m_cyc.size();
            @(posedge clk16);
            #1;
            t0 = cyc + 1;
            send_line(mk_frame(d, 8, 0, 1'b0, {1'b1, st}), 10, 1'b0);
            wait_mon(1'b0, base + 1, ok);
            total++; if (!ok) $display("FAIL rand_timeout[%0d]: got no rx_valid, expected one", k); else pass_cnt++;
            if (ok) begin
                total++; if (m_d[base] !== d) $display("FAIL rand_data[%0d]: got %h expected %h", k, m_d[base], d); else pass_cnt++;
                total++; if (m_fe[base] !== !st) $display("FAIL rand_frame_err[%0d]: got %b expected %b", k, m_fe[base], !st); else pass_cnt++;
                total++; if (m_cyc[base] - t0 !== exp_lat(10)) $display("FAIL rand_latency[%0d]: got %0d expected %0d", k, m_cyc[base] - t0, exp_lat(10)); else pass_cnt++;
            end
            repeat (2 * OS) @(posedge clk16);
        end
    endtask

    task automatic test_glitch();
        int base, t0, rise, fall;
        base = m_cyc.size();
        @(posedge clk16);
        #1;
        t0   = cyc + 1;
        rise = -1;
        fall = -1;
        sdi  = 1'b0;
        for (int j = 0; j < 40; j++) begin
            @(posedge clk16);
            #1;
            if (j == 5) sdi = 1'b1;
            if (bsy && rise < 0) rise = cyc;
            if (!bsy && rise >= 0 && fall < 0) fall = cyc;
        end
        total++; if (rise !== t0 + 2) $display("FAIL glitch_start: got busy at %0d expected %0d", rise, t0 + 2); else pass_cnt++;
        total++; if (fall < 0 || fall - rise > 10) $display("FAIL glitch_reject: got busy for %0d clocks expected at most 10", fall - rise); else pass_cnt++;
        repeat (160) @(posedge clk16);
        #1;
        total++; if (m_cyc.size() !== base) $display("FAIL glitch_no_valid: got %0d words expected 0", m_cyc.size() - base); else pass_cnt++;
    endtask

    task automatic test_parity();
        int base, t0;
        bit ok;
        logic [8:0] d;
        logic pb, exp_pe;
        for (int k = 0; k < 6; k++) begin
            if (k < 2) begin
                d  = 9'h041;
                pb = (k == 0) ? 1'b1 : 1'b0;
            end else begin
                d  = 9'($urandom_range(0, 127));
                pb = 1'($urandom_range(0, 1));
            end
            exp_pe = (^d[6:0]) ^ pb;
            base = p_cyc.size();
            @(posedge clk16);
            #1;
            t0 = cyc + 1;
            send_line(mk_frame(d, 7, 1, pb, 2'b11), 10, 1'b1);
            wait_mon(1'b1, base + 1, ok);
            total++; if (!ok) $display("FAIL par_timeout[%0d]: got no rx_valid, expected one", k); else pass_cnt++;
            if (ok) begin
                total++; if (p_d[base] !== d) $display("FAIL par_data[%0d]: got %h expected %h", k, p_d[base], d); else pass_cnt++;
                total++; if (p_pe[base] !== exp_pe) $display("FAIL par_err[%0d]: got %b expected %b", k, p_pe[base], exp_pe); else pass_cnt++;
                total++; if ({p_fe[base], p_cyc[base] - t0 == exp_lat(10)} !== 2'b01) $display("FAIL par_fe_latency[%0d]: got fe=%b lat=%0d expected fe=0 lat=%0d", k, p_fe[base], p_cyc[base] - t0, exp_lat(10)); else pass_cnt++;
            end
            repeat (OS) @(posedge clk16);
        end
    endtask

    task automatic test_frame_err();
        int base;
        bit ok;
        base = m_cyc.size();
        @(posedge clk16);
        #1;
        send_line(mk_frame(9'h03C, 8, 0, 1'b0, 2'b10), 10, 1'b0);
        wait_mon(1'b0, base + 1, ok);
        total++; if (!ok) $display("FAIL ferr_timeout: got no rx_valid, expected one"); else pass_cnt++;
        if (ok) begin
            total++; if (m_d[base] !== 9'h03C) $display("FAIL ferr_data: got %h expected 03c", m_d[base]); else pass_cnt++;
            total++; if ({m_fe[base], m_pe[base]} !== 2'b10) $display("FAIL ferr_flags: got %b expected 10", {m_fe[base], m_pe[base]}); else pass_cnt++;
        end
        repeat (2 * OS) @(posedge clk16);
    endtask

    task automatic test_back_to_back();
        rdy = 1'b0;
        @(posedge clk16);
        #1;
        send_line(mk_frame(9'h011, 8, 0, 1'b0, 2'b11), 10, 1'b0);
        total++; if ({vld, ovr, dout} !== {1'b1, 1'b0, 8'h11}) $display("FAIL b2b_first: got v=%b o=%b d=%h expected v=1 o=0 d=11", vld, ovr, dout); else pass_cnt++;
        send_line(mk_frame(9'h022, 8, 0, 1'b0, 2'b11), 10, 1'b0);
        total++; if (dout !== 8'h22) $display("FAIL b2b_data: got %h expected 22", dout); else pass_cnt++;
        total++; if ({vld, ovr} !== 2'b11) $display("FAIL b2b_overrun: got v=%b o=%b expected v=1 o=1", vld, ovr); else pass_cnt++;
        rdy = 1'b1;
        @(posedge clk16);
        #1;
        total++; if (vld !== 1'b0) $display("FAIL b2b_accept: got valid %b expected 0", vld); else pass_cnt++;
        repeat (OS) @(posedge clk16);
        #1;
        total++; if ({ovr, dout} !== {1'b1, 8'h22}) $display("FAIL b2b_sticky: got o=%b d=%h expected o=1 d=22", ovr, dout); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int base;
        bit ok;
        base = m_cyc.size();
        @(posedge clk16);
        #1;
        sdi = 1'b0;
        repeat (OS) begin
            @(posedge clk16);
            #1;
        end
        sdi = 1'b1;
        repeat (3 * OS + 5) begin
            @(posedge clk16);
            #1;
        end
        total++; if (bsy !== 1'b1) $display("FAIL rmid_busy: got %b expected 1", bsy); else pass_cnt++;
        rst = 1'b1;
        #1;
        total++; if ({bsy, ovr, vld} !== 3'b000) $display("FAIL rmid_async: got b=%b o=%b v=%b expected 000", bsy, ovr, vld); else pass_cnt++;
        repeat (3) @(posedge clk16);
        #1;
        rst = 1'b0;
        repeat (200) @(posedge clk16);
        #1;
        total++; if (m_cyc.size() !== base) $display("FAIL rmid_discard: got %0d words expected 0", m_cyc.size() - base); else pass_cnt++;
        send_line(mk_frame(9'h00F, 8, 0, 1'b0, 2'b11), 10, 1'b0);
        wait_mon(1'b0, base + 1, ok);
        total++; if (!ok) $display("FAIL rmid_timeout: got no rx_valid, expected one"); else pass_cnt++;
        if (ok) begin
            total++; if ({m_fe[base], m_d[base]} !== {1'b0, 9'h00F}) $display("FAIL rmid_data: got fe=%b d=%h expected fe=0 d=00f", m_fe[base], m_d[base]); else pass_cnt++;
        end
        repeat (OS) @(posedge clk16);
    endtask

    task automatic test_line_low();
        int base, t0;
        bit ok;
        base = m_cyc.size();
        @(posedge clk16);
        #1;
        t0  = cyc + 1;
        sdi = 1'b0;
        repeat (10 * OS) begin
            @(posedge clk16);
            #1;
        end
        sdi = 1'b1;
        repeat (3 * OS) @(posedge clk16);
        #1;
        total++; if (m_cyc.size() !== base + 1) $display("FAIL low_count: got %0d words expected 1", m_cyc.size() - base); else pass_cnt++;
        if (m_cyc.size() > base) begin
            total++; if ({m_fe[base], m_d[base]} !== {1'b1, 9'h000}) $display("FAIL low_word: got fe=%b d=%h expected fe=1 d=000", m_fe[base], m_d[base]); else pass_cnt++;
            total++; if (m_cyc[base] - t0 !== exp_lat(10)) $display("FAIL low_latency: got %0d expected %0d", m_cyc[base] - t0, exp_lat(10)); else pass_cnt++;
`ifdef UART_RX_BREAK_DETECT_EN
            total++; if (m_brk[base] !== 1'b1) $display("FAIL low_break: got %b expected 1", m_brk[base]); else pass_cnt++;
`endif
        end
        send_line(mk_frame(9'h05A, 8, 0, 1'b0, 2'b11), 10, 1'b0);
        wait_mon(1'b0, base + 2, ok);
        total++; if (!ok) $display("FAIL low_next_timeout: got no rx_valid, expected one"); else pass_cnt++;
        if (ok) begin
            total++; if ({m_brk[base+1], m_fe[base+1], m_d[base+1]} !== {1'b0, 1'b0, 9'h05A}) $display("FAIL low_next: got brk=%b fe=%b d=%h expected 0 0 05a", m_brk[base+1], m_fe[base+1], m_d[base+1]); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random_frames();
        test_glitch();
        test_parity();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_line_low();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
